// File: rtl/sw_marker_ctrl.sv
// Sweep sequencer for the 12-bit sweep-marker datapath: steps a code from start to stop, raising pipeline-aligned marker and done strobes.
// Optional build macro SW_MARKER_REPEAT_EN adds the Repeat input for continuous re-sweeping.
module sw_marker_ctrl #(
    parameter int WIDTH      = 12,
    parameter int PIPE_DEPTH = 3,
    parameter int DWELL_W    = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Abort,
`ifdef SW_MARKER_REPEAT_EN
    input  logic               Repeat,
`endif
    input  logic [WIDTH-1:0]   StartCode,
    input  logic [WIDTH-1:0]   StopCode,
    input  logic [WIDTH-1:0]   StepCode,
    input  logic [DWELL_W-1:0] Dwell,
    input  logic [WIDTH-1:0]   MarkerCode,
    output logic [WIDTH-1:0]   SweepCode,
    output logic               Busy,
    output logic               MarkerOut,
    output logic               DoneOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r, state_nxt;
    logic [WIDTH-1:0]     sweep_r, sweep_nxt;
    logic [DWELL_W-1:0]   dwell_r, dwell_nxt;
    logic                 busy_r, busy_nxt;
    logic                 armed_r, armed_nxt;
    logic                 marker_raw_r, marker_nxt;
    logic                 done_raw_s;
    logic                 latch_s;
    logic [WIDTH-1:0]     next_pt_s;

    logic [WIDTH-1:0]     start_sh_r, stop_sh_r, step_sh_r, mk_sh_r;
    logic [DWELL_W-1:0]   dwell_sh_r;
    logic                 up_sh_r;

    logic [PIPE_DEPTH-1:0] marker_pipe_r;
    logic [PIPE_DEPTH-1:0] done_pipe_r;

    // The extra carry/borrow bit keeps 4095+step and 0-step from wrapping before the clamp.
    function automatic logic [WIDTH-1:0] next_point(input logic [WIDTH-1:0] cur,
                                                    input logic [WIDTH-1:0] stop,
                                                    input logic [WIDTH-1:0] step,
                                                    input logic             up);
        logic [WIDTH:0] sum;
        logic [WIDTH:0] diff;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        if (up) begin
            if (sum > {1'b0, stop}) next_point = stop;
            else                    next_point = sum[WIDTH-1:0];
        end else begin
            if (diff[WIDTH] || (diff[WIDTH-1:0] < stop)) next_point = stop;
            else                                         next_point = diff[WIDTH-1:0];
        end
    endfunction

    function automatic logic crossed(input logic [WIDTH-1:0] v,
                                     input logic [WIDTH-1:0] mk,
                                     input logic             up);
        if (up) crossed = (v >= mk);
        else    crossed = (v <= mk);
    endfunction

    // Candidate next sweep point from the latched sweep parameters.
    always_comb begin
        next_pt_s = next_point(sweep_r, stop_sh_r, step_sh_r, up_sh_r);
    end

    // Next-state and datapath-update decode.
    always_comb begin
        state_nxt  = state_r;
        sweep_nxt  = sweep_r;
        dwell_nxt  = dwell_r;
        busy_nxt   = busy_r;
        armed_nxt  = armed_r;
        marker_nxt = 1'b0;
        done_raw_s = 1'b0;
        latch_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (Start && !Abort) begin
                    latch_s    = 1'b1;
                    sweep_nxt  = StartCode;
                    dwell_nxt  = Dwell;
                    busy_nxt   = 1'b1;
                    state_nxt  = HOLD;
                    marker_nxt = crossed(StartCode, MarkerCode, StopCode >= StartCode);
                    armed_nxt  = !marker_nxt;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (Abort) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    armed_nxt = 1'b0;
                end else if (dwell_r != {DWELL_W{1'b0}}) begin
                    dwell_nxt = dwell_r - {{(DWELL_W-1){1'b0}}, 1'b1};
                end else if (sweep_r == stop_sh_r) begin
`ifdef SW_MARKER_REPEAT_EN
                    if (Repeat) begin
                        done_raw_s = 1'b1;
                        sweep_nxt  = start_sh_r;
                        dwell_nxt  = dwell_sh_r;
                        marker_nxt = crossed(start_sh_r, mk_sh_r, up_sh_r);
                        armed_nxt  = !marker_nxt;
                    end else begin
                        state_nxt = DONE;
                    end
`else
                    state_nxt = DONE;
`endif
                end else begin
                    sweep_nxt = next_pt_s;
                    dwell_nxt = dwell_sh_r;
                    if (armed_r && crossed(next_pt_s, mk_sh_r, up_sh_r)) begin
                        marker_nxt = 1'b1;
                        armed_nxt  = 1'b0;
                    end else begin
                        armed_nxt = armed_r;
                    end
                end
            end
            DONE: begin
                done_raw_s = 1'b1;
                busy_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                armed_nxt = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) state_r <= IDLE;
        else       state_r <= state_nxt;
    end

    // Sweep code, dwell counter, busy and marker-arming registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sweep_r      <= {WIDTH{1'b0}};
            dwell_r      <= {DWELL_W{1'b0}};
            busy_r       <= 1'b0;
            armed_r      <= 1'b0;
            marker_raw_r <= 1'b0;
        end else begin
            sweep_r      <= sweep_nxt;
            dwell_r      <= dwell_nxt;
            busy_r       <= busy_nxt;
            armed_r      <= armed_nxt;
            marker_raw_r <= marker_nxt;
        end
    end

    // Shadow copy of the sweep parameters, frozen for the whole sweep; step 0 behaves as step 1.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            start_sh_r <= {WIDTH{1'b0}};
            stop_sh_r  <= {WIDTH{1'b0}};
            step_sh_r  <= {WIDTH{1'b0}};
            mk_sh_r    <= {WIDTH{1'b0}};
            dwell_sh_r <= {DWELL_W{1'b0}};
            up_sh_r    <= 1'b0;
        end else if (latch_s) begin
            start_sh_r <= StartCode;
            stop_sh_r  <= StopCode;
            step_sh_r  <= (StepCode == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : StepCode;
            mk_sh_r    <= MarkerCode;
            dwell_sh_r <= Dwell;
            up_sh_r    <= (StopCode >= StartCode);
        end else begin
            start_sh_r <= start_sh_r;
        end
    end

    // Strobe delay lines matching the datapath latency.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            marker_pipe_r <= {PIPE_DEPTH{1'b0}};
            done_pipe_r   <= {PIPE_DEPTH{1'b0}};
        end else begin
            marker_pipe_r[0] <= marker_raw_r;
            done_pipe_r[0]   <= done_raw_s;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                marker_pipe_r[i] <= marker_pipe_r[i-1];
                done_pipe_r[i]   <= done_pipe_r[i-1];
            end
        end
    end

    assign SweepCode = sweep_r;
    assign Busy      = busy_r;
    assign MarkerOut = marker_pipe_r[PIPE_DEPTH-1];
    assign DoneOut   = done_pipe_r[PIPE_DEPTH-1];

endmodule

// File: tb/tb_sw_marker_ctrl.sv
// Self-checking bench for sw_marker_ctrl: per-cycle expectations are queued from a reference sweep model and popped as the DUT runs.
module tb_sw_marker_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic        Repeat = 1'b0;
    logic [11:0] StartCode = 12'd0;
    logic [11:0] StopCode = 12'd0;
    logic [11:0] StepCode = 12'd0;
    logic [15:0] Dwell = 16'd0;
    logic [11:0] MarkerCode = 12'd0;
    logic [11:0] SweepCode;
    logic        Busy;
    logic        MarkerOut;
    logic        DoneOut;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [11:0] code;
        logic        busy;
        logic        mk;
        logic        dn;
    } exp_t;

    exp_t sb_q[$];

    always #5 Clock = ~Clock;

    sw_marker_ctrl dut (
        .Clock(Clock),
        .Reset(Reset),
        .Start(Start),
        .Abort(Abort),
`ifdef SW_MARKER_REPEAT_EN
        .Repeat(Repeat),
`endif
        .StartCode(StartCode),
        .StopCode(StopCode),
        .StepCode(StepCode),
        .Dwell(Dwell),
        .MarkerCode(MarkerCode),
        .SweepCode(SweepCode),
        .Busy(Busy),
        .MarkerOut(MarkerOut),
        .DoneOut(DoneOut)
    );

    task automatic set_inputs(input int s, input int p, input int st, input int dw, input int mk);
        StartCode  = 12'(s);
        StopCode   = 12'(p);
        StepCode   = 12'(st);
        Dwell      = 16'(dw);
        MarkerCode = 12'(mk);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        total += 4;
        if (SweepCode !== 12'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", SweepCode); end
        if (Busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        if (MarkerOut !== 1'b0)  begin bad++; $display("FAIL reset_marker got=%b exp=0", MarkerOut); end
        if (DoneOut !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b exp=0", DoneOut); end
    endtask

    // Reference model: point list, then per-cycle expectations starting the cycle after the Start edge.
    task automatic test_sweep(input int s, input int p, input int st, input int dw, input int mk, input string nm);
        int   pts[$];
        int   cur, step, n, len, mj, mkc, k;
        bit   up;
        exp_t e;
        up   = (p >= s);
        step = (st == 0) ? 1 : st;
        cur  = s;
        pts.push_back(cur);
        while (cur != p) begin
            if (up) cur = (cur + step > p) ? p : cur + step;
            else    cur = (cur - step < p) ? p : cur - step;
            pts.push_back(cur);
        end
        n   = pts.size();
        len = n * (dw + 1) + 1;
        mj  = -1;
        foreach (pts[j]) if (mj < 0 && (up ? pts[j] >= mk : pts[j] <= mk)) mj = j;
        mkc = (mj < 0) ? -1 : mj * (dw + 1) + 1 + 3;
        for (int c = 1; c <= len + 4; c++) begin
            e.code = (c <= n * (dw + 1)) ? 12'(pts[(c - 1) / (dw + 1)]) : 12'(pts[n - 1]);
            e.busy = (c <= len);
            e.mk   = (c == mkc);
            e.dn   = (c == len + 3);
            sb_q.push_back(e);
        end
        @(negedge Clock);
        set_inputs(s, p, st, dw, mk);
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        set_inputs($urandom_range(4095), $urandom_range(4095), $urandom_range(4095), $urandom_range(7), $urandom_range(4095));
        k = 0;
        while (sb_q.size() > 0) begin
            @(negedge Clock);
            k++;
            e = sb_q.pop_front();
            total += 4;
            if (SweepCode !== e.code) begin bad++; $display("FAIL %s_code c%0d got=%0d exp=%0d", nm, k, SweepCode, e.code); end
            if (Busy !== e.busy)      begin bad++; $display("FAIL %s_busy c%0d got=%b exp=%b", nm, k, Busy, e.busy); end
            if (MarkerOut !== e.mk)   begin bad++; $display("FAIL %s_marker c%0d got=%b exp=%b", nm, k, MarkerOut, e.mk); end
            if (DoneOut !== e.dn)     begin bad++; $display("FAIL %s_done c%0d got=%b exp=%b", nm, k, DoneOut, e.dn); end
        end
    endtask

    task automatic test_abort();
        @(negedge Clock);
        set_inputs(100, 110, 4, 1, 105);
        Start = 1'b1;
        @(posedge Clock);
        #1;
        StartCode = 12'd500;
        @(negedge Clock);
        total++;
        if (SweepCode !== 12'd100) begin bad++; $display("FAIL abort_first got=%0d exp=100", SweepCode); end
        @(posedge Clock);
        #1;
        Start = 1'b0;
        @(negedge Clock);
        total++;
        if (SweepCode !== 12'd100) begin bad++; $display("FAIL start_while_busy got=%0d exp=100", SweepCode); end
        @(negedge Clock);
        total++;
        if (SweepCode !== 12'd104) begin bad++; $display("FAIL abort_second got=%0d exp=104", SweepCode); end
        Abort = 1'b1;
        @(posedge Clock);
        #1;
        Abort = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clock);
            total += 4;
            if (Busy !== 1'b0)         begin bad++; $display("FAIL abort_busy c%0d got=%b exp=0", c, Busy); end
            if (SweepCode !== 12'd104) begin bad++; $display("FAIL abort_hold c%0d got=%0d exp=104", c, SweepCode); end
            if (DoneOut !== 1'b0)      begin bad++; $display("FAIL abort_done c%0d got=%b exp=0", c, DoneOut); end
            if (MarkerOut !== 1'b0)    begin bad++; $display("FAIL abort_marker c%0d got=%b exp=0", c, MarkerOut); end
        end
        @(negedge Clock);
        set_inputs(1, 9, 1, 0, 0);
        Start = 1'b1;
        Abort = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        Abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clock);
            total += 2;
            if (Busy !== 1'b0)         begin bad++; $display("FAIL start_abort_busy c%0d got=%b exp=0", c, Busy); end
            if (SweepCode !== 12'd104) begin bad++; $display("FAIL start_abort_code c%0d got=%0d exp=104", c, SweepCode); end
        end
    endtask

    // Raw marker sits in cycle 5 (first cycle at 108); reset is sampled at the end of cycle 6.
    task automatic test_reset_mid();
        @(negedge Clock);
        set_inputs(100, 110, 4, 1, 105);
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        for (int c = 1; c <= 6; c++) @(negedge Clock);
        total++;
        if (SweepCode !== 12'd108) begin bad++; $display("FAIL rst_mid_pre got=%0d exp=108", SweepCode); end
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        for (int c = 7; c <= 11; c++) begin
            total += 4;
            if (SweepCode !== 12'd0) begin bad++; $display("FAIL rst_mid_code c%0d got=%0d exp=0", c, SweepCode); end
            if (Busy !== 1'b0)       begin bad++; $display("FAIL rst_mid_busy c%0d got=%b exp=0", c, Busy); end
            if (MarkerOut !== 1'b0)  begin bad++; $display("FAIL rst_mid_marker c%0d got=%b exp=0", c, MarkerOut); end
            if (DoneOut !== 1'b0)    begin bad++; $display("FAIL rst_mid_done c%0d got=%b exp=0", c, DoneOut); end
            @(negedge Clock);
        end
    endtask

`ifdef SW_MARKER_REPEAT_EN
    // Points 0,4,8 with no dwell: 3-cycle passes, Repeat dropped during the third pass.
    task automatic test_repeat();
        int dn_cnt, mk_cnt;
        dn_cnt = 0;
        mk_cnt = 0;
        @(negedge Clock);
        set_inputs(0, 8, 4, 0, 4);
        Repeat = 1'b1;
        Start  = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge Clock);
            if (c == 7) Repeat = 1'b0;
            if (DoneOut === 1'b1) dn_cnt++;
            if (MarkerOut === 1'b1) mk_cnt++;
            if (c == 9) begin
                total++;
                if (Busy !== 1'b1) begin bad++; $display("FAIL repeat_busy got=%b exp=1", Busy); end
            end
        end
        total += 3;
        if (dn_cnt != 3)   begin bad++; $display("FAIL repeat_done_count got=%0d exp=3", dn_cnt); end
        if (mk_cnt != 3)   begin bad++; $display("FAIL repeat_marker_count got=%0d exp=3", mk_cnt); end
        if (Busy !== 1'b0) begin bad++; $display("FAIL repeat_end_busy got=%b exp=0", Busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_sweep(100, 110, 4, 1, 105, "up");
        test_sweep(50, 10, 20, 0, 40, "down");
        test_sweep(4090, 4095, 3, 0, 4093, "clamp");
        test_sweep(7, 9, 0, 0, 8, "zero_step");
        test_sweep(0, 20, 5, 0, 30, "no_cross");
        test_sweep(5, 5, 1, 2, 5, "single");
        test_sweep(10, 0, 50, 1, 3, "underflow");
        test_abort();
        test_reset_mid();
`ifdef SW_MARKER_REPEAT_EN
        test_repeat();
`endif
        test_sweep(30, 20, 3, 0, 25, "back_to_back");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
